// File: rtl/reg8_access_arbiter.sv
// reg8_access_arbiter
//   Shares one 8-entry x 8-bit register file (reg8) among N requesters.
//   A round-robin arbiter picks one pending command in IDLE, latches it,
//   performs it against reg8 during a single ACCESS cycle, and pulses the
//   requester's ack in DONE. At most one access completes every 3 cycles.
//
// Optional feature macro: REG_ARB_LOCK_EN
//   When defined, a lock port lets the current winner keep top priority
//   for up to LOCK_MAX back-to-back grants.
//
// Ports
//   clk      in   1    clock, rising edge
//   rst      in   1    asynchronous reset, active-low
//   req      in   N    request per requester, held until ack
//   wr       in   N    1 = write, 0 = read
//   addr     in   3*N  register index, requester i in [3i+2:3i]
//   wdata    in   8*N  write data, requester i in [8i+7:8i]
//   lock     in   N    keep priority after access (REG_ARB_LOCK_EN only)
//   gnt      out  N    one-hot, registered, high during ACCESS
//   ack      out  N    one-hot, 1-cycle pulse during DONE
//   rdata    out  8    read data, valid in ack cycle, otherwise holds
//   rf_in    out  8    reg8 write data
//   rf_load  out  3    reg8 write index
//   rf_we    out  1    reg8 write strobe
//   rf_sel   out  3    reg8 read index
//   rf_out   in   8    reg8 read data (combinational from rf_sel)

module reg8_access_arbiter #(
   parameter int N        = 4,
   parameter int LOCK_MAX = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   wr,
   input  logic [3*N-1:0] addr,
   input  logic [8*N-1:0] wdata,
`ifdef REG_ARB_LOCK_EN
   input  logic [N-1:0]   lock,
`endif
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   ack,
   output logic [7:0]     rdata,
   output logic [7:0]     rf_in,
   output logic [2:0]     rf_load,
   output logic           rf_we,
   output logic [2:0]     rf_sel,
   input  logic [7:0]     rf_out
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   ptr, ptr_nx;
   logic [PW-1:0]   win, win_nx;
   logic            lat_wr, wr_nx;
   logic [2:0]      lat_addr, addr_nx;
   logic [7:0]      lat_wdata, wdata_nx;
   logic [N-1:0]    gnt_nx, ack_nx;
   logic [7:0]      rdata_nx;

`ifdef REG_ARB_LOCK_EN
   localparam int CW = $clog2(LOCK_MAX) + 1;
   logic [CW-1:0]   cnt, cnt_nx;
`endif

   // Per-requester command fields, unpacked so they can be indexed by winner
   logic [2:0] addr_a  [N];
   logic [7:0] wdata_a [N];

   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign addr_a[g]  = addr[3*g +: 3];
      assign wdata_a[g] = wdata[8*g +: 8];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= '0;
         win       <= '0;
         lat_wr    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         gnt       <= '0;
         ack       <= '0;
         rdata     <= '0;
`ifdef REG_ARB_LOCK_EN
         cnt       <= '0;
`endif
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         win       <= win_nx;
         lat_wr    <= wr_nx;
         lat_addr  <= addr_nx;
         lat_wdata <= wdata_nx;
         gnt       <= gnt_nx;
         ack       <= ack_nx;
         rdata     <= rdata_nx;
`ifdef REG_ARB_LOCK_EN
         cnt       <= cnt_nx;
`endif
      end
   end

   always_comb begin
      logic          found;
      logic [PW-1:0] pick;
      logic [PW:0]   sum;

      state_nx = state;
      ptr_nx   = ptr;
      win_nx   = win;
      wr_nx    = lat_wr;
      addr_nx  = lat_addr;
      wdata_nx = lat_wdata;
      gnt_nx   = gnt;
      ack_nx   = ack;
      rdata_nx = rdata;
`ifdef REG_ARB_LOCK_EN
      cnt_nx   = cnt;
`endif
      rf_we    = 1'b0;
      rf_load  = '0;
      rf_in    = '0;
      rf_sel   = '0;

      // First pending request at or after ptr, wrapping N-1 -> 0
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(N))
            sum = sum - (PW+1)'(N);
         if (!found && req[sum[PW-1:0]]) begin
            found = 1'b1;
            pick  = sum[PW-1:0];
         end
      end

      case (state)
         IDLE: begin
            gnt_nx = '0;
            ack_nx = '0;
            if (found) begin
               win_nx       = pick;
               wr_nx        = wr[pick];
               addr_nx      = addr_a[pick];
               wdata_nx     = wdata_a[pick];
               gnt_nx[pick] = 1'b1;
               state_nx     = ACCESS;
            end
         end
         ACCESS: begin
            // Strobes decode from state so reset removes them immediately
            rf_we = lat_wr;
            if (lat_wr) begin
               rf_load = lat_addr;
               rf_in   = lat_wdata;
            end else begin
               rf_sel   = lat_addr;
               rdata_nx = rf_out;
            end
            gnt_nx      = '0;
            ack_nx      = '0;
            ack_nx[win] = 1'b1;
            state_nx    = DONE;
         end
         DONE: begin
            ack_nx   = '0;
            state_nx = IDLE;
`ifdef REG_ARB_LOCK_EN
            // cnt counts extra grants already kept, so a locked requester
            // receives at most LOCK_MAX grants in a row in total
            if (lock[win] && req[win] && (int'({1'b0, cnt}) < LOCK_MAX - 1)) begin
               ptr_nx = win;
               cnt_nx = cnt + 1'b1;
            end else begin
               ptr_nx = (win == PW'(N-1)) ? '0 : win + 1'b1;
               cnt_nx = '0;
            end
`else
            ptr_nx = (win == PW'(N-1)) ? '0 : win + 1'b1;
`endif
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg8_access_arbiter.sv
module tb_reg8_access_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, wr;
   logic [3*N-1:0] addr;
   logic [8*N-1:0] wdata;
`ifdef REG_ARB_LOCK_EN
   logic [N-1:0]   lock;
`endif
   logic [N-1:0]   gnt, ack;
   logic [7:0]     rdata, rf_in, rf_out;
   logic [2:0]     rf_load, rf_sel;
   logic           rf_we;

   logic [7:0]     mem [8];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Behavioural reg8: synchronous write, combinational read
   always @(posedge clk) if (rf_we) mem[rf_load] <= rf_in;
   assign rf_out = mem[rf_sel];

   reg8_access_arbiter #(.N(N), .LOCK_MAX(4)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
`ifdef REG_ARB_LOCK_EN
      .lock(lock),
`endif
      .gnt(gnt), .ack(ack), .rdata(rdata), .rf_in(rf_in), .rf_load(rf_load),
      .rf_we(rf_we), .rf_sel(rf_sel), .rf_out(rf_out)
   );

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   task automatic test_reset();
      rst = 1'b0; req = '0; wr = '0; addr = '0; wdata = '0;
`ifdef REG_ARB_LOCK_EN
      lock = '0;
`endif
      repeat (2) @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b want 0000", gnt); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack got %b want 0000", ack); end
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h want 00", rdata); end
      checks++; if ({rf_we, rf_load, rf_sel, rf_in} !== 15'd0) begin errors++; $display("FAIL rst_rf got %b want 0", {rf_we, rf_load, rf_sel, rf_in}); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt got %b want 0000", gnt); end
   endtask

   task automatic test_contention();
      int exp;
      req = 4'b1111; wr = 4'b1111;
      for (int i = 0; i < N; i++) begin
         addr[3*i +: 3]  = 3'(i);
         wdata[8*i +: 8] = 8'h10 + 8'(i);
      end
      for (int k = 0; k < 5; k++) begin
         exp = k % N;
         @(negedge clk);
         checks++; if (gnt !== 4'(1 << exp)) begin errors++; $display("FAIL cont_gnt%0d got %b want %b", k, gnt, 4'(1 << exp)); end
         checks++; if (rf_we !== 1'b1 || rf_in !== 8'h10 + 8'(exp) || rf_load !== 3'(exp)) begin errors++; $display("FAIL cont_wr%0d got we=%b in=%h ld=%0d want we=1 in=%h ld=%0d", k, rf_we, rf_in, rf_load, 8'h10 + 8'(exp), exp); end
         @(negedge clk);
         checks++; if (ack !== 4'(1 << exp) || gnt !== 4'b0000) begin errors++; $display("FAIL cont_ack%0d got ack=%b gnt=%b want ack=%b gnt=0000", k, ack, gnt, 4'(1 << exp)); end
         if (k == 4) req = '0;
         @(negedge clk);
         checks++; if (ack !== 4'b0000 || gnt !== 4'b0000 || rf_we !== 1'b0) begin errors++; $display("FAIL cont_gap%0d got ack=%b gnt=%b we=%b want 0", k, ack, gnt, rf_we); end
      end
      for (int i = 0; i < N; i++) begin
         checks++; if (mem[i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL cont_mem%0d got %h want %h", i, mem[i], 8'h10 + 8'(i)); end
      end
   endtask

   task automatic test_write_read();
      req = 4'b0001; wr = 4'b0001; addr[2:0] = 3'd5; wdata[7:0] = 8'hA7;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001 || ack !== 4'b0000) begin errors++; $display("FAIL w_gnt got gnt=%b ack=%b want 0001/0000", gnt, ack); end
      checks++; if (rf_we !== 1'b1 || rf_load !== 3'd5 || rf_in !== 8'hA7) begin errors++; $display("FAIL w_rf got we=%b ld=%0d in=%h want 1/5/a7", rf_we, rf_load, rf_in); end
      // Command was latched at grant; later changes must not leak through
      wdata[7:0] = 8'h55; addr[2:0] = 3'd1;
      @(negedge clk);
      checks++; if (ack !== 4'b0001 || gnt !== 4'b0000 || rf_we !== 1'b0) begin errors++; $display("FAIL w_ack got ack=%b gnt=%b we=%b want 0001/0000/0", ack, gnt, rf_we); end
      checks++; if (mem[5] !== 8'hA7 || mem[1] !== 8'h11) begin errors++; $display("FAIL w_mem got m5=%h m1=%h want a7/11", mem[5], mem[1]); end
      req = '0;
      @(negedge clk);
      req = 4'b0001; wr = 4'b0000; addr[2:0] = 3'd5;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001 || rf_sel !== 3'd5 || rf_we !== 1'b0) begin errors++; $display("FAIL r_gnt got gnt=%b sel=%0d we=%b want 0001/5/0", gnt, rf_sel, rf_we); end
      @(negedge clk);
      checks++; if (ack !== 4'b0001 || rdata !== 8'hA7) begin errors++; $display("FAIL r_ack got ack=%b rdata=%h want 0001/a7", ack, rdata); end
      req = '0;
      repeat (2) @(negedge clk);
      checks++; if (rdata !== 8'hA7 || ack !== 4'b0000) begin errors++; $display("FAIL r_hold got rdata=%h ack=%b want a7/0000", rdata, ack); end
   endtask

   task automatic test_wrap();
      // Grant requester 2 alone so the pointer moves to 3
      req = 4'b0100; wr = 4'b0000;
      @(negedge clk);
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_pre got %b want 0100", gnt); end
      @(negedge clk);
      req = 4'b0101;
      @(negedge clk);
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_first got %b want 0001", gnt); end
      @(negedge clk);
      checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wrap_ack0 got %b want 0001", ack); end
      req[0] = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_second got %b want 0100", gnt); end
      @(negedge clk);
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_drop_req();
      req = 4'b0010; wr = 4'b0010; addr[5:3] = 3'd2; wdata[15:8] = 8'h5A;
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_gnt got %b want 0010", gnt); end
      req = '0;
      @(negedge clk);
      checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL drop_ack got %b want 0010", ack); end
      checks++; if (mem[2] !== 8'h5A) begin errors++; $display("FAIL drop_mem got %h want 5a", mem[2]); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      req = 4'b1000; wr = 4'b1000; addr[11:9] = 3'd7; wdata[31:24] = 8'h3C;
      @(negedge clk);
      checks++; if (gnt !== 4'b1000 || rf_we !== 1'b1) begin errors++; $display("FAIL mid_gnt got gnt=%b we=%b want 1000/1", gnt, rf_we); end
      #2 rst = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0000 || ack !== 4'b0000 || rf_we !== 1'b0) begin errors++; $display("FAIL mid_async got gnt=%b ack=%b we=%b want 0", gnt, ack, rf_we); end
      req = '0;
      @(negedge clk);
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL mid_noack got %b want 0000", ack); end
      rst = 1'b1; req = 4'b1111; wr = 4'b0000; addr = '0;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_first got %b want 0001", gnt); end
      @(negedge clk);
      checks++; if (ack !== 4'b0001 || rdata !== 8'h10) begin errors++; $display("FAIL mid_read got ack=%b rdata=%h want 0001/10", ack, rdata); end
      req = '0;
      repeat (2) @(negedge clk);
   endtask

`ifdef REG_ARB_LOCK_EN
   task automatic test_lock();
      int exp;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0011; wr = 4'b0000; lock = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         exp = (k < 4) ? 0 : 1;
         @(negedge clk);
         checks++; if (gnt !== 4'(1 << exp)) begin errors++; $display("FAIL lock_gnt%0d got %b want %b", k, gnt, 4'(1 << exp)); end
         @(negedge clk);
         if (k == 4) req = '0;
         @(negedge clk);
      end
      lock = '0;
   endtask
`endif

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      test_reset();
      test_contention();
      test_write_read();
      test_wrap();
      test_drop_req();
      test_reset_mid();
`ifdef REG_ARB_LOCK_EN
      test_lock();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
